// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered LSU/MUL results into one register-file
// write port and tracks outstanding long-latency destinations. Optional macro: WB_FAIR_EN.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_idx,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_idx,
  input  logic [XLEN-1:0]               lsu_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_idx,
  input  logic [4:0]                    chk_idx1,
  input  logic [4:0]                    chk_idx2,
  output logic                          busy1,
  output logic                          busy2,
  output logic                          alu_stall,
  output logic                          wr_en,
  output logic [4:0]                    wr_idx,
  output logic [XLEN-1:0]               wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [4:0]      fifo_idx_q  [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            wr_en_q;
  logic [4:0]      wr_idx_q;
  logic [XLEN-1:0] wr_data_q;

  logic            push, pop, alu_sel;
  logic [4:0]      head_idx;
  logic [XLEN-1:0] head_data;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign lsu_ready = (count_q != FULL);

`ifdef WB_FAIR_EN
  assign alu_stall = alu_valid & (count_q == FULL);
`else
  assign alu_stall = 1'b0;
`endif

  assign head_idx  = fifo_idx_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign push    = lsu_valid & lsu_ready & (lsu_idx != 5'd0);
  assign alu_sel = alu_valid & (alu_idx != 5'd0) & ~alu_stall;
  assign pop     = ~alu_sel & (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Issue is applied after the pop clear so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_idx] = 1'b0;
    end
    if (issue_valid && issue_idx != 5'd0) begin
      busy_d[issue_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign busy1 = busy_q[chk_idx1];
  assign busy2 = busy_q[chk_idx2];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= lsu_idx;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else if (alu_sel) begin
      wr_en_q   <= 1'b1;
      wr_idx_q  <= alu_idx;
      wr_data_q <= alu_data;
    end else if (pop) begin
      wr_en_q   <= 1'b1;
      wr_idx_q  <= head_idx;
      wr_data_q <= head_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_idx     = wr_idx_q;
  assign wr_data    = wr_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for the single-cycle behaviour plus hand-written
// sequences for FIFO-full arbitration and asynchronous reset mid-traffic.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_idx, lsu_idx, issue_idx, chk_idx1, chk_idx2;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, busy1, busy2, alu_stall, wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_idx(lsu_idx), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .chk_idx1(chk_idx1), .chk_idx2(chk_idx2), .busy1(busy1), .busy2(busy2),
    .alu_stall(alu_stall), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic        av;  logic [4:0] ai; logic [31:0] ad;
    logic        lv;  logic [4:0] li; logic [31:0] ld;
    logic        iv;  logic [4:0] ii;
    logic [4:0]  c1;  logic [4:0] c2;
    logic        ewe; logic [4:0] ewi; logic [31:0] ewd;
    logic [2:0]  ecnt; logic erdy; logic eb1; logic eb2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ai, input logic [31:0] ad,
    input logic lv, input logic [4:0] li, input logic [31:0] ld,
    input logic iv, input logic [4:0] ii, input logic [4:0] c1, input logic [4:0] c2,
    input logic ewe, input logic [4:0] ewi, input logic [31:0] ewd,
    input logic [2:0] ecnt, input logic erdy, input logic eb1, input logic eb2);
    vec_t v;
    v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ld = ld;
    v.iv = iv; v.ii = ii; v.c1 = c1; v.c2 = c2;
    v.ewe = ewe; v.ewi = ewi; v.ewd = ewd; v.ecnt = ecnt; v.erdy = erdy; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_idx = 0; alu_data = 0;
    lsu_valid = 0; lsu_idx = 0; lsu_data = 0;
    issue_valid = 0; issue_idx = 0;
  endtask

  task automatic check_wr(input string tag, input logic ewe, input logic [4:0] ewi,
                          input logic [31:0] ewd, input logic [2:0] ecnt);
    check({tag, " wr_en"}, 64'(wr_en), 64'(ewe));
    check({tag, " wr_idx"}, 64'(wr_idx), 64'(ewi));
    check({tag, " wr_data"}, 64'(wr_data), 64'(ewd));
    check({tag, " count"}, 64'(fifo_count), 64'(ecnt));
    $display("%s: wr_en=%0b idx=%0d data=%h count=%0d stall=%0b",
             tag, wr_en, wr_idx, wr_data, fifo_count, alu_stall);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    chk_idx1 = 0; chk_idx2 = 0;

    // idx 17/19 are used for busy tracking so FIFO traffic on idx 1..5 leaves them alone
    //            av ai  ad            lv li  ld          iv ii  c1  c2  we wi  wd            cnt rdy b1 b2
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 0,  7,  5, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  7,  5, 0, 5, 32'hDEADBEEF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          1, 7,  7,  5, 0, 5, 32'hDEADBEEF, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h12,     0, 0,  7,  5, 0, 5, 32'hDEADBEEF, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  7,  5, 1, 7, 32'h12,       0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h111,      1, 0, 32'h222,    1, 0,  0,  0, 0, 7, 32'h12,       0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h333,      1, 0, 32'h444,    1, 0,  0,  7, 0, 7, 32'h12,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          1, 17, 17, 19, 0, 7, 32'h12,      0, 1, 1, 0));
    vecs.push_back(mk(1, 19, 32'hAAAA,    0, 0, 0,          1, 19, 17, 19, 1, 19, 32'hAAAA,   0, 1, 1, 1));
    vecs.push_back(mk(1, 10, 32'hA0,      1, 1, 32'h101,    0, 0,  17, 19, 1, 10, 32'hA0,     1, 1, 1, 1));
    vecs.push_back(mk(1, 11, 32'hA1,      1, 2, 32'h102,    0, 0,  17, 19, 1, 11, 32'hA1,     2, 1, 1, 1));
    vecs.push_back(mk(1, 12, 32'hA2,      1, 3, 32'h103,    0, 0,  17, 19, 1, 12, 32'hA2,     3, 1, 1, 1));
    vecs.push_back(mk(1, 13, 32'hA3,      1, 4, 32'h104,    0, 0,  17, 19, 1, 13, 32'hA3,     4, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 5, 32'h105,    0, 0,  17, 19, 1, 1, 32'h101,     3, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 5, 32'h105,    0, 0,  17, 19, 1, 2, 32'h102,     3, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 1, 3, 32'h103,     2, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 1, 4, 32'h104,     1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 1, 5, 32'h105,     0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 0, 5, 32'h105,     0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 17, 32'h33,    0, 0,  17, 19, 0, 5, 32'h105,     1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 1, 17, 32'h33,     0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 19, 32'h99,    0, 0,  17, 19, 0, 17, 32'h33,     1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          1, 19, 17, 19, 1, 19, 32'h99,     0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 19, 32'h98,    0, 0,  17, 19, 0, 19, 32'h99,     1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  17, 19, 1, 19, 32'h98,     0, 1, 0, 0));

    tick();
    tick();
    check_wr("reset", 0, 0, 0, 0);
    check("reset lsu_ready", 64'(lsu_ready), 64'(1));
    check("reset alu_stall", 64'(alu_stall), 64'(0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_idx = vecs[i].ai; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_idx = vecs[i].li; lsu_data = vecs[i].ld;
      issue_valid = vecs[i].iv; issue_idx = vecs[i].ii;
      chk_idx1 = vecs[i].c1; chk_idx2 = vecs[i].c2;
      tick();
      check_wr($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ewi, vecs[i].ewd, vecs[i].ecnt);
      check($sformatf("vec%0d lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].erdy));
      check($sformatf("vec%0d busy1", i), 64'(busy1), 64'(vecs[i].eb1));
      check($sformatf("vec%0d busy2", i), 64'(busy2), 64'(vecs[i].eb2));
    end

    // Fill the FIFO behind a continuous ALU stream; idx 30 goes busy along the way.
    chk_idx1 = 30; chk_idx2 = 24;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_idx = 5'(21 + k); alu_data = 32'hC0 + 32'(k);
      lsu_valid = 1; lsu_idx = 5'(24 + k); lsu_data = 32'hD0 + 32'(k);
      issue_valid = (k == 0); issue_idx = 30;
      tick();
      check_wr($sformatf("fill%0d", k), 1, 5'(21 + k), 32'hC0 + 32'(k), 3'(k + 1));
    end
    check("full lsu_ready", 64'(lsu_ready), 64'(0));
    check("full busy1", 64'(busy1), 64'(1));
    lsu_valid = 0; issue_valid = 0;
    alu_valid = 1; alu_idx = 28; alu_data = 32'hE0;
    #1;

`ifdef WB_FAIR_EN
    check("fair alu_stall", 64'(alu_stall), 64'(1));
    tick();
    check_wr("fair head", 1, 24, 32'hD0, 3);
    check("fair stall released", 64'(alu_stall), 64'(0));
    tick();
    check_wr("fair alu", 1, 28, 32'hE0, 3);
`else
    check("alu_wins alu_stall", 64'(alu_stall), 64'(0));
    tick();
    check_wr("alu_wins0", 1, 28, 32'hE0, 4);
    alu_data = 32'hE1;
    tick();
    check_wr("alu_wins1", 1, 28, 32'hE1, 4);
    alu_valid = 0;
    tick();
    check_wr("drain", 1, 24, 32'hD0, 3);
`endif

    // Reset lands mid-cycle with results queued, a write in flight and a busy bit set.
    alu_valid = 0;
    lsu_valid = 1; lsu_idx = 29; lsu_data = 32'hF0;
    check("pre-reset busy1", 64'(busy1), 64'(1));
    rst = 1'b1;
    #1;
    check_wr("async_reset", 0, 0, 0, 0);
    check("async_reset lsu_ready", 64'(lsu_ready), 64'(1));
    check("async_reset busy1", 64'(busy1), 64'(0));
    check("async_reset busy2", 64'(busy2), 64'(0));
    check("async_reset alu_stall", 64'(alu_stall), 64'(0));
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check_wr("post_reset", 0, 0, 0, 0);
    tick();
    check_wr("post_reset2", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
